// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg
// Shared constants and types for the FIFO read-side drain stage.
//   FIFO_RD_LAT    : cycles from an accepted pop to valid fifo_rd_data
//   OUT_BUF_DEPTH  : entries in the output skid buffer
//   stream_beat_t  : {data, last} beat at the default 8-bit data width
//   pkt_cnt_width(): width of the packet beat counter for a given PKT_LEN
package fifo_rd_stream_pkg;

    localparam int FIFO_RD_LAT   = 1;
    localparam int OUT_BUF_DEPTH = 2;
    localparam int DEF_DATA_SIZE = 8;

    typedef struct packed {
        logic [DEF_DATA_SIZE-1:0] data;
        logic                     last;
    } stream_beat_t;

    // PKT_LEN=1 still needs a 1-bit counter so the compare stays legal.
    function automatic int pkt_cnt_width(input int pkt_len);
        return (pkt_len > 1) ? $clog2(pkt_len) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if
// Valid/ready output stream of the FIFO drain stage.
//   m_valid : beat valid          (master -> slave)
//   m_data  : beat data           (master -> slave)
//   m_last  : last beat of packet (master -> slave)
//   m_ready : sink ready          (slave -> master)
interface fifo_rd_stream_if #(
    parameter int DATA_SIZE = 8
);
    logic                 m_valid;
    logic [DATA_SIZE-1:0] m_data;
    logic                 m_last;
    logic                 m_ready;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/fifo_rd_skid_buf.sv
// fifo_rd_skid_buf
// Two-entry in-order buffer of {data, last} beats.
//   clk, rst  : clock, asynchronous active-high reset
//   push      : store push_beat this cycle
//   push_beat : incoming beat
//   pop       : head entry is consumed this cycle
//   head_beat : oldest stored beat (registered)
//   occ       : number of stored beats, 0..2
// The caller guarantees no push when full and no pop when empty.
module fifo_rd_skid_buf #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_beat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_beat,
    output logic [1:0]       occ
);
    logic [WIDTH-1:0] tail_beat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_beat <= '0;
            tail_beat <= '0;
            occ       <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head_beat <= push_beat;
                    else             tail_beat <= push_beat;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head_beat <= tail_beat;
                    occ       <= occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; new beat lands behind whatever remains.
                    if (occ == 2'd1) begin
                        head_beat <= push_beat;
                    end else begin
                        head_beat <= tail_beat;
                        tail_beat <= push_beat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// Drains fifo_top's read port into a valid/ready stream, hiding the FIFO's
// one-cycle read latency behind a two-entry skid buffer so a continuously
// ready sink gets one beat per cycle. Tags every PKT_LEN-th beat with m_last
// and counts delivered beats.
//   rd_clk, rd_rst : read clock, asynchronous active-high reset
//   fifo_empty     : fifo_top empty flag
//   fifo_rd_en     : pop request to fifo_top
//   fifo_rd_data   : fifo_top read data, valid the cycle after a pop
//   m_stream       : output stream (master side)
//   beat_count     : beats accepted by the sink since reset, wrapping
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int PKT_LEN   = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [DATA_SIZE-1:0] fifo_rd_data,
    fifo_rd_stream_if.master     m_stream,
    output logic [CNT_W-1:0]     beat_count
);
    localparam int               PKT_W    = pkt_cnt_width(PKT_LEN);
    localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(PKT_LEN - 1);
    localparam int               BEAT_W   = DATA_SIZE + 1;

    logic              inflight;
    logic [PKT_W-1:0]  pkt_cnt;
    logic [1:0]        occ;
    logic [BEAT_W-1:0] head_beat;
    logic [BEAT_W-1:0] cap_beat;
    logic              m_valid;
    logic              xfer;
    logic              cap_last;
    logic [2:0]        committed;

    assign m_valid = (occ != 2'd0);
    assign xfer    = m_valid && m_stream.m_ready;

    // Slots already spoken for after this edge: stored + in flight - leaving.
    // Issuing only while this is below the buffer depth makes overflow impossible.
    assign committed  = {1'b0, occ} + {2'b00, inflight} - {2'b00, xfer};
    assign fifo_rd_en = !rd_rst && !fifo_empty && (committed < 3'(OUT_BUF_DEPTH));

    assign cap_last = (pkt_cnt == PKT_LAST);
    assign cap_beat = {fifo_rd_data, cap_last};

    fifo_rd_skid_buf #(
        .WIDTH (BEAT_W)
    ) u_buf (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .push      (inflight),
        .push_beat (cap_beat),
        .pop       (xfer),
        .head_beat (head_beat),
        .occ       (occ)
    );

    assign m_stream.m_valid = m_valid;
    assign m_stream.m_data  = head_beat[BEAT_W-1:1];
    assign m_stream.m_last  = head_beat[0];

    // fifo_rd_en is already qualified by !fifo_empty, so it marks an accepted pop.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) inflight <= 1'b0;
        else        inflight <= fifo_rd_en;
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            pkt_cnt <= '0;
        end else if (inflight) begin
            pkt_cnt <= cap_last ? '0 : pkt_cnt + PKT_W'(1);
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst)    beat_count <= '0;
        else if (xfer) beat_count <= beat_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream
// Directed bench: a behavioural fifo_top read port feeds two DUT copies
// (PKT_LEN=4/CNT_W=16 and PKT_LEN=1/CNT_W=4) driven by the same inputs.
module tb_fifo_rd_stream;
    import fifo_rd_stream_pkg::*;

    typedef struct {
        stream_beat_t beat;
        logic         last2;
        int           cyc;
    } rx_t;

    logic        rd_clk = 1'b0;
    logic        rd_rst = 1'b0;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        fifo_rd_en2;
    logic [7:0]  fifo_rd_data = 8'h00;
    logic [15:0] beat_count;
    logic [3:0]  beat_count2;

    fifo_rd_stream_if #(.DATA_SIZE(8)) s_if ();
    fifo_rd_stream_if #(.DATA_SIZE(8)) s_if2 ();
    assign s_if2.m_ready = s_if.m_ready;

    fifo_rd_stream #(.DATA_SIZE(8), .PKT_LEN(4), .CNT_W(16)) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .m_stream     (s_if),
        .beat_count   (beat_count)
    );

    fifo_rd_stream #(.DATA_SIZE(8), .PKT_LEN(1), .CNT_W(4)) dut2 (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en2),
        .fifo_rd_data (fifo_rd_data),
        .m_stream     (s_if2),
        .beat_count   (beat_count2)
    );

    always #5 rd_clk = ~rd_clk;

    // Behavioural fifo_top read side: wr_ptr owned by the stimulus, rd_ptr by the model.
    logic [7:0] fmem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= fmem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    int cyc = 0;
    always @(posedge rd_clk) cyc <= cyc + 1;

    // Sink/invariant monitor, sampled one time unit before each rising edge.
    rx_t rx[$];
    int  pop_cnt = 0;
    int  viol    = 0;
    always @(negedge rd_clk) begin
        #4;
        if (!rd_rst) begin
            if (s_if.m_valid && s_if.m_ready)
                rx.push_back('{beat: '{data: s_if.m_data, last: s_if.m_last},
                               last2: s_if2.m_last, cyc: cyc});
            if (fifo_rd_en && !fifo_empty) pop_cnt++;
            if (fifo_rd_en && fifo_empty) viol++;
            if (int'(dut.occ) + int'(dut.inflight) > 2) viol++;
            if (fifo_rd_en2 !== fifo_rd_en) viol++;
            if (s_if2.m_valid !== s_if.m_valid) viol++;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        fmem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic push_list(input logic [7:0] w[$]);
        foreach (w[i]) push_word(w[i]);
    endtask

    task automatic reset_dut();
        @(negedge rd_clk);
        rd_rst = 1'b1;
        @(negedge rd_clk);
        rd_rst = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int n, input int max_cyc);
        int k = 0;
        while (rx.size() < n && k < max_cyc) begin
            @(negedge rd_clk);
            k++;
        end
        if (rx.size() < n) check_eq({tag, "_timeout"}, rx.size(), n);
    endtask

    task automatic check_beats(input string tag, input int base, input logic [7:0] exp[$],
                               input int pkt);
        foreach (exp[i]) begin
            check_eq($sformatf("%s_data%0d", tag, i), rx[base+i].beat.data, exp[i]);
            check_eq($sformatf("%s_last%0d", tag, i), rx[base+i].beat.last,
                     ((i % pkt) == pkt - 1) ? 1 : 0);
        end
    endtask

    logic [7:0] t_order[$] = '{8'hA5, 8'h3C, 8'h7E, 8'h1F};
    logic [7:0] t_bp[$]    = '{8'hA5, 8'h3C, 8'h7E, 8'h1F, 8'hC2, 8'h69,
                               8'hB0, 8'h44, 8'hE1, 8'h5A, 8'h96, 8'h8D};
    logic [7:0] t_gap[$]   = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54};
    logic [7:0] t_tog[$]   = '{8'hF7, 8'h2E, 8'h5C, 8'hB9, 8'h73, 8'hE6, 8'hCD, 8'h9B,
                               8'h37, 8'h6E, 8'hDC, 8'hB8, 8'h71, 8'hE2, 8'hC5, 8'h8B};
    logic [7:0] t_pre[$]   = '{8'h11, 8'h22};
    logic [7:0] t_post[$]  = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] t_wrap[$];

    initial begin
        int b;
        int t0;
        int p0;
        int k;
        int n_l2;
        int tp[5];

        s_if.m_ready = 1'b0;

        // Reset values, with a word waiting in the FIFO so rd_en gating is visible.
        #1 rd_rst = 1'b1;
        push_word(8'hEE);
        #6;
        check_eq("rst_m_valid", s_if.m_valid, 0);
        check_eq("rst_m_data", s_if.m_data, 0);
        check_eq("rst_m_last", s_if.m_last, 0);
        check_eq("rst_beat_count", beat_count, 0);
        check_eq("rst_rd_en", fifo_rd_en, 0);
        reset_dut();

        // Stream order and first-word latency.
        s_if.m_ready = 1'b1;
        b = rx.size();
        @(negedge rd_clk);
        t0 = cyc;
        push_list(t_order);
        wait_beats("order", b + 4, 20);
        check_beats("order", b, t_order, 4);
        check_eq("order_latency", rx[b].cyc - t0, FIFO_RD_LAT + 1);
        for (int i = 1; i < 4; i++)
            check_eq($sformatf("order_gap%0d", i), rx[b+i].cyc - rx[b+i-1].cyc, 1);
        check_eq("order_beat_count", beat_count, 4);
        repeat (3) @(negedge rd_clk);
        check_eq("order_drained_valid", s_if.m_valid, 0);
        check_eq("order_fifo_empty", fifo_empty, 1);

        // Backpressure: only two pops while the sink stalls.
        reset_dut();
        s_if.m_ready = 1'b0;
        b = rx.size();
        @(negedge rd_clk);
        p0 = pop_cnt;
        push_list(t_bp);
        repeat (10) @(negedge rd_clk);
        check_eq("bp_pops", pop_cnt - p0, 2);
        check_eq("bp_rd_en", fifo_rd_en, 0);
        check_eq("bp_m_valid", s_if.m_valid, 1);
        check_eq("bp_m_data", s_if.m_data, 8'hA5);
        check_eq("bp_no_xfer", rx.size() - b, 0);
        s_if.m_ready = 1'b1;
        wait_beats("bp", b + 12, 40);
        check_beats("bp", b, t_bp, 4);
        check_eq("bp_beat_count", beat_count, 12);

        // Sparse writes: each word reaches the sink two cycles after empty drops.
        reset_dut();
        s_if.m_ready = 1'b1;
        b = rx.size();
        for (int i = 0; i < 5; i++) begin
            @(negedge rd_clk);
            tp[i] = cyc;
            push_word(t_gap[i]);
            repeat (2) @(negedge rd_clk);
        end
        wait_beats("gap", b + 5, 20);
        check_beats("gap", b, t_gap, 4);
        for (int i = 0; i < 5; i++)
            check_eq($sformatf("gap_latency%0d", i), rx[b+i].cyc - tp[i], 2);
        repeat (4) @(negedge rd_clk);
        check_eq("gap_count", rx.size() - b, 5);

        // Alternating ready.
        reset_dut();
        b = rx.size();
        @(negedge rd_clk);
        push_list(t_tog);
        k = 0;
        while (rx.size() < b + 16 && k < 100) begin
            @(negedge rd_clk);
            s_if.m_ready = ~s_if.m_ready;
            k++;
        end
        if (rx.size() < b + 16) check_eq("tog_timeout", rx.size(), b + 16);
        @(negedge rd_clk);
        s_if.m_ready = 1'b1;
        check_beats("tog", b, t_tog, 4);
        check_eq("tog_beat_count", beat_count, 16);

        // Reset right after the pop of D4.
        reset_dut();
        s_if.m_ready = 1'b1;
        b = rx.size();
        push_list(t_pre);
        wait_beats("pre", b + 2, 20);
        check_eq("pre_beat_count", beat_count, 2);
        push_word(8'hD4);
        @(posedge rd_clk);
        #1 rd_rst = 1'b1;
        #1;
        check_eq("mrst_m_valid", s_if.m_valid, 0);
        check_eq("mrst_beat_count", beat_count, 0);
        check_eq("mrst_rd_en", fifo_rd_en, 0);
        @(negedge rd_clk);
        rd_rst = 1'b0;
        b = rx.size();
        @(negedge rd_clk);
        push_list(t_post);
        wait_beats("post", b + 4, 20);
        check_beats("post", b, t_post, 4);
        repeat (4) @(negedge rd_clk);
        check_eq("post_count", rx.size() - b, 4);

        // 17 beats: the 4-bit counter wraps to 1, PKT_LEN=1 copy marks every beat.
        reset_dut();
        s_if.m_ready = 1'b1;
        b = rx.size();
        for (int i = 0; i < 17; i++) t_wrap.push_back(8'((i * 29 + 5) & 255));
        @(negedge rd_clk);
        push_list(t_wrap);
        wait_beats("wrap", b + 17, 60);
        check_eq("wrap_beat_count16", beat_count, 17);
        check_eq("wrap_beat_count4", beat_count2, 1);
        n_l2 = 0;
        for (int i = 0; i < 17; i++) if (rx[b+i].last2 === 1'b1) n_l2++;
        check_eq("wrap_last_pkt1", n_l2, 17);
        check_eq("wrap_last15", rx[b+15].beat.last, 1);
        check_eq("wrap_last16", rx[b+16].beat.last, 0);
        check_eq("wrap_data16", rx[b+16].beat.data, t_wrap[16]);

        check_eq("invariants", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
